mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, word-address bits; the internal array holds 2^ADDR_WIDTH 32-bit words.
REQ-002 Parameter WAIT_CYCLES, default 2, number of wait-state cycles per access; legal range 0..15.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 MemRead  input  1  read request from the main controller FSM.
REQ-006 MemWrite  input  1  write request from the main controller FSM.
REQ-007 Address  input  32  byte address.
REQ-008 WriteData  input  32  store data; the low byte or low half is used for SB/SH.
REQ-009 Funct3  input  3  access size and sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-010 ReadData  output  32  extended load result, registered.
REQ-011 MemReady  output  1  one-cycle completion strobe.
REQ-012 MemBusy  output  1  high in every state except IDLE.
REQ-013 MemError  output  1  misaligned-access flag, valid only with MemReady.

Function
REQ-014 The FSM SHALL have four states: IDLE, WAIT, ACCESS and DONE.
REQ-015 In IDLE, a rising edge with MemRead or MemWrite high SHALL capture Address, WriteData, Funct3 and the request type.
  - Next state: WAIT if WAIT_CYCLES > 0, otherwise ACCESS.
REQ-016 MemWrite SHALL take priority when MemRead and MemWrite are both high; the request is treated as a write.
REQ-017 WAIT SHALL last exactly WAIT_CYCLES cycles, counted by a 4-bit down-counter, then go to ACCESS.
REQ-018 ACCESS SHALL last one cycle and perform the array read or write; the next state is DONE.
REQ-019 DONE SHALL last one cycle; MemReady is high only in DONE; the next state is IDLE.
REQ-020 MemReady SHALL rise exactly WAIT_CYCLES+1 rising edges after the capture edge.
REQ-021 Requests arriving outside IDLE SHALL be ignored; the captured values are held until DONE.
REQ-022 A request present in the DONE cycle SHALL NOT be captured; the earliest new capture is the IDLE cycle that follows.
REQ-023 Word index SHALL be Address[ADDR_WIDTH+1:2]; higher address bits are ignored, so addresses wrap.
REQ-024 SW SHALL write all 4 bytes.
  - SH writes the half selected by Address[1].
  - SB writes the byte selected by Address[1:0].
  - Unwritten bytes of the word are preserved.
REQ-025 LB/LH SHALL sign-extend the selected byte or half; LBU/LHU SHALL zero-extend; LW returns the full word.
REQ-026 Funct3 values 011, 110 and 111 SHALL be treated as word accesses.
REQ-027 ReadData SHALL update only on the ACCESS edge of a read and otherwise hold its value; writes leave it unchanged.

Reset
REQ-028 rst SHALL have priority over all other logic.
  - Forces state IDLE.
  - Sets ReadData=0, MemReady=0, MemBusy=0, MemError=0, wait counter=0.
REQ-029 Reset asserted on what would be the ACCESS edge SHALL abort the access: no array write and no ReadData update.
REQ-030 Array contents SHALL NOT be altered by reset.

Configuration
REQ-031 Macro MEM_MISALIGN_TRAP_EN SHALL select misaligned-access trapping.
REQ-032 With MEM_MISALIGN_TRAP_EN defined, the following accesses are misaligned:
  - a halfword access with Address[0]=1;
  - a word access with Address[1:0]≠0.
  A misaligned access SHALL:
  - skip the array access;
  - leave ReadData unchanged;
  - assert MemError together with MemReady in DONE.
  Latency is unchanged.
REQ-033 Without the macro, MemError SHALL be tied to 0.
  - Word accesses ignore Address[1:0].
  - Halfword accesses ignore Address[0].

Verification
REQ-034 WAIT_CYCLES=2: SW 0xDEADBEEF to 0x10, MemRead LW 0x10 → MemReady on the 3rd edge after capture, ReadData=0xDEADBEEF.
REQ-035 SB 0x80 to 0x11 over word 0x00000000 → LW 0x10=0x00008000; LB 0x11=0xFFFFFF80; LBU 0x11=0x00000080.
REQ-036 SH 0x8001 to 0x12 → LH 0x12=0xFFFF8001; LHU 0x12=0x00008001; LW 0x10=0x80010000.
REQ-037 MemRead and MemWrite both high at 0x20 with 0x5 → treated as write; a later LW 0x20 returns 5; MemBusy is 1 for WAIT_CYCLES+2 cycles.
REQ-038 rst pulsed during WAIT of SW 0x1234 to 0x30 → IDLE next cycle, no MemReady, LW 0x30 returns prior contents.
REQ-039 With MEM_MISALIGN_TRAP_EN, LW 0x13 → MemReady=1, MemError=1, ReadData unchanged; without the macro, LW 0x13 returns word 0x10 and MemError=0.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: word-organised data memory that answers load/store requests
// from a multicycle controller with a fixed number of wait states.
//
// Parameters
//   ADDR_WIDTH   word-address bits; the array holds 2**ADDR_WIDTH 32-bit words
//   WAIT_CYCLES  wait-state cycles per access (0..15)
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset (array contents are kept)
//   MemRead    read request, sampled only in IDLE
//   MemWrite   write request, sampled only in IDLE, wins over MemRead
//   Address    byte address; bits above ADDR_WIDTH+1 are ignored (wrap)
//   WriteData  store data; low byte / low half used for SB / SH
//   Funct3     000 B, 001 H, 010 W, 100 BU, 101 HU; 011/110/111 act as W
//   ReadData   extended load result, registered
//   MemReady   one-cycle completion strobe (DONE state)
//   MemBusy    high whenever the responder is not IDLE
//   MemError   misaligned-access flag, meaningful only with MemReady
//
// Optional feature macro: MEM_MISALIGN_TRAP_EN
//   Defined   : misaligned halfword/word accesses skip the array, leave
//               ReadData alone and raise MemError alongside MemReady.
//   Undefined : MemError is 0; word accesses ignore Address[1:0] and
//               halfword accesses ignore Address[0].
module mem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic [2:0]  Funct3,
  output logic [31:0] ReadData,
  output logic        MemReady,
  output logic        MemBusy,
  output logic        MemError
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH+1:0]   addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [2:0]              funct3_q, funct3_d;
  logic                    write_q, write_d;
  logic [31:0]             rdata_q;
  logic [31:0]             mem_q [DEPTH];

  // Address bits above the word index only exist to be discarded.
  logic unused_addr_bits;
  assign unused_addr_bits = ^Address[31:ADDR_WIDTH+2];

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      write_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      write_q  <= write_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    write_d  = write_q;
    case (state_q)
      S_IDLE: begin
        if (MemRead || MemWrite) begin
          addr_d   = Address[ADDR_WIDTH+1:0];
          wdata_d  = WriteData;
          funct3_d = Funct3;
          write_d  = MemWrite;
          cnt_d    = WAIT_LOAD;
          state_d  = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        // Counter was loaded with WAIT_CYCLES on capture; the cycle in
        // which it reads 1 is the last wait cycle.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_ACCESS;
      end
      S_ACCESS: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ---------------- access decode ----------------
  logic is_byte, is_half, is_word, misalign, do_access;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [3:0]  be;
  logic [31:0] wlane;

  assign is_byte  = (funct3_q[1:0] == 2'b00);
  assign is_half  = (funct3_q[1:0] == 2'b01);
  assign is_word  = funct3_q[1];
  assign word_idx = addr_q[ADDR_WIDTH+1:2];

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = (is_half && addr_q[0]) || (is_word && (addr_q[1:0] != 2'b00));
  assign MemError = (state_q == S_DONE) && misalign;
`else
  assign misalign = 1'b0;
  assign MemError = 1'b0;
`endif

  assign do_access = (state_q == S_ACCESS) && !misalign;

  // Per-lane byte enable and store data: halves and bytes are replicated
  // across the word so the enabled lane always carries the right bits.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign be[gi] = is_word
                    | (is_half && (addr_q[1] == 1'(gi >> 1)))
                    | (is_byte && (addr_q[1:0] == 2'(gi)));
      assign wlane[8*gi +: 8] = is_word ? wdata_q[8*gi +: 8]
                              : is_half ? wdata_q[8*(gi % 2) +: 8]
                              : wdata_q[7:0];
    end
  endgenerate

  // ---------------- storage ----------------
  // Reset gates the write so an access interrupted on its ACCESS edge has
  // no effect; the array itself is never cleared.
  always_ff @(posedge clk) begin
    if (!rst && do_access && write_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[word_idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  logic [31:0] rword, load_val;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign rword    = mem_q[word_idx];
  assign sel_byte = rword[8*addr_q[1:0] +: 8];
  assign sel_half = addr_q[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    load_val = rword;
    case (funct3_q)
      3'b000:  load_val = {{24{sel_byte[7]}}, sel_byte};
      3'b100:  load_val = {24'd0, sel_byte};
      3'b001:  load_val = {{16{sel_half[15]}}, sel_half};
      3'b101:  load_val = {16'd0, sel_half};
      default: load_val = rword;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (do_access && !write_q) begin
      rdata_q <= load_val;
    end
  end

  assign ReadData = rdata_q;
  assign MemReady = (state_q == S_DONE);
  assign MemBusy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  localparam int AW    = 10;
  localparam int W     = 2;
  localparam int DEPTH = 1 << AW;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead, MemWrite;
  logic [31:0] Address, WriteData;
  logic [2:0]  Funct3;
  logic [31:0] ReadData;
  logic        MemReady, MemBusy, MemError;

  mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Address   (Address),
    .WriteData (WriteData),
    .Funct3    (Funct3),
    .ReadData  (ReadData),
    .MemReady  (MemReady),
    .MemBusy   (MemBusy),
    .MemError  (MemError)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: plain word array plus the expected ReadData value.
  logic [31:0] mdl_mem [DEPTH];
  logic [31:0] rdata_exp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & 32'(DEPTH - 1));
  endfunction

  function automatic bit mdl_misaligned(input logic [2:0] f3, input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
    if (f3 == 3'd1 || f3 == 3'd5) return (a % 2) != 0;
    if (f3 == 3'd0 || f3 == 3'd4) return 1'b0;
    return (a % 4) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] mdl_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] w, b, h;
    w = mdl_mem[widx(a)];
    b = (w >> (8 * (a % 4))) & 32'hFF;
    h = ((a / 2) % 2 == 1) ? (w >> 16) : (w & 32'hFFFF);
    case (f3)
      3'd0:    return (b >= 128) ? (b | 32'hFFFFFF00) : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? (h | 32'hFFFF0000) : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  task automatic mdl_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] w, mask, val;
    int sh;
    w = mdl_mem[widx(a)];
    if (f3 == 3'd0 || f3 == 3'd4) begin
      sh = 8 * (a % 4);
      mask = 32'hFF << sh;
      val = (d & 32'hFF) << sh;
    end else if (f3 == 3'd1 || f3 == 3'd5) begin
      sh = ((a / 2) % 2 == 1) ? 16 : 0;
      mask = 32'hFFFF << sh;
      val = (d & 32'hFFFF) << sh;
    end else begin
      mask = 32'hFFFFFFFF;
      val = d;
    end
    mdl_mem[widx(a)] = (w & ~mask) | val;
  endtask

  // One complete transaction. With hold_junk set, a junk write request is
  // kept asserted (with changing address/data) until after the DONE edge;
  // it must neither disturb the captured access nor be captured itself.
  task automatic do_xfer(input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d, input bit hold_junk);
    int n, busy;
    bit mis;
    @(negedge clk);
    MemRead = rd; MemWrite = wr; Funct3 = f3; Address = a; WriteData = d;
    @(posedge clk); #1;
    busy = MemBusy ? 1 : 0;
    if (hold_junk) begin
      MemRead = 1'b1; MemWrite = 1'b1; Funct3 = 3'd2;
      Address = 32'($urandom_range(0, 15) * 4); WriteData = $urandom;
    end else begin
      MemRead = 1'b0; MemWrite = 1'b0;
      Address = $urandom; WriteData = $urandom; Funct3 = 3'($urandom);
    end
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (MemBusy) busy++;
      if (MemReady) break;
    end
    mis = mdl_misaligned(f3, a);
    if (!mis) begin
      if (wr) mdl_store(f3, a, d);
      else    rdata_exp = mdl_load(f3, a);
    end
    $display("[TB] %s f3=%0d addr=0x%08h wdata=0x%08h -> rdata=0x%08h err=%0b lat=%0d",
             wr ? "WR" : "RD", f3, a, d, ReadData, MemError, n);
    check("latency", 32'(n), 32'(W + 1));
    check("rdata", ReadData, rdata_exp);
    check("error", {31'd0, MemError}, {31'd0, mis});
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0;
    check("idle_after_done", {31'd0, MemBusy}, 32'd0);
    check("busy_cycles", 32'(busy), 32'(W + 2));
  endtask

  // Store that is cut short by reset after edges_before edges past capture.
  task automatic do_abort(input logic [31:0] a, input logic [31:0] d, input int edges_before);
    int stray;
    @(negedge clk);
    MemWrite = 1'b1; Funct3 = 3'd2; Address = a; WriteData = d;
    @(posedge clk); #1;
    MemWrite = 1'b0;
    repeat (edges_before) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rdata_exp = 32'd0;
    $display("[TB] ABORT addr=0x%08h wdata=0x%08h after %0d edges busy=%0b", a, d, edges_before, MemBusy);
    check("abort_busy", {31'd0, MemBusy}, 32'd0);
    check("abort_rdata", ReadData, 32'd0);
    stray = 0;
    repeat (W + 4) begin
      @(posedge clk); #1;
      if (MemReady) stray++;
    end
    check("abort_no_ready", 32'(stray), 32'd0);
  endtask

  initial begin
    rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
    Address = '0; WriteData = '0; Funct3 = '0;
    rdata_exp = 32'd0;
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  {31'd0, MemBusy},  32'd0);
    check("rst_ready", {31'd0, MemReady}, 32'd0);
    check("rst_error", {31'd0, MemError}, 32'd0);
    check("rst_rdata", ReadData, 32'd0);
    rst = 1'b0;

    // Give the working pool (words 0..15) known contents.
    for (int i = 0; i < 16; i++) do_xfer(0, 1, 3'd2, 32'(i * 4), $urandom, 0);

    // Directed cases.
    do_xfer(0, 1, 3'd2, 32'h10, 32'hDEADBEEF, 0);
    do_xfer(1, 0, 3'd2, 32'h10, 32'h0, 0);
    check("lw_deadbeef", ReadData, 32'hDEADBEEF);

    do_xfer(0, 1, 3'd2, 32'h10, 32'h0, 0);
    do_xfer(0, 1, 3'd0, 32'h11, 32'h80, 0);
    do_xfer(1, 0, 3'd2, 32'h10, 32'h0, 0);
    check("sb_lw", ReadData, 32'h00008000);
    do_xfer(1, 0, 3'd0, 32'h11, 32'h0, 0);
    check("sb_lb", ReadData, 32'hFFFFFF80);
    do_xfer(1, 0, 3'd4, 32'h11, 32'h0, 0);
    check("sb_lbu", ReadData, 32'h00000080);

    do_xfer(0, 1, 3'd2, 32'h10, 32'h0, 0);
    do_xfer(0, 1, 3'd1, 32'h12, 32'h8001, 0);
    do_xfer(1, 0, 3'd1, 32'h12, 32'h0, 0);
    check("sh_lh", ReadData, 32'hFFFF8001);
    do_xfer(1, 0, 3'd5, 32'h12, 32'h0, 0);
    check("sh_lhu", ReadData, 32'h00008001);
    do_xfer(1, 0, 3'd2, 32'h10, 32'h0, 0);
    check("sh_lw", ReadData, 32'h80010000);

    do_xfer(1, 1, 3'd2, 32'h20, 32'h5, 0);
    do_xfer(1, 0, 3'd2, 32'h20, 32'h0, 0);
    check("rw_prio", ReadData, 32'h5);

    do_xfer(0, 1, 3'd2, 32'h30, 32'hA5A5_0F0F, 0);
    do_abort(32'h30, 32'h1234, 0);
    do_xfer(1, 0, 3'd2, 32'h30, 32'h0, 0);
    check("abort_wait_keep", ReadData, 32'hA5A5_0F0F);
    do_abort(32'h30, 32'h5678, W);
    do_xfer(1, 0, 3'd2, 32'h30, 32'h0, 0);
    check("abort_access_keep", ReadData, 32'hA5A5_0F0F);

    do_xfer(1, 0, 3'd2, 32'h10, 32'h0, 1);
    do_xfer(1, 0, 3'd2, 32'h13, 32'h0, 0);

    // Address wrap: high bits above the word index are ignored.
    do_xfer(0, 1, 3'd2, 32'h8000_1004, 32'h0BAD_F00D, 0);
    do_xfer(1, 0, 3'd2, 32'h4, 32'h0, 0);
    check("wrap", ReadData, 32'h0BAD_F00D);

    // Randomized traffic over the pool, with random high address bits.
    for (int t = 0; t < 200; t++) begin
      logic [2:0]  f3;
      logic [31:0] a;
      bit wr, rd, junk;
      wr = ($urandom_range(0, 1) == 1);
      rd = wr ? ($urandom_range(0, 9) == 0) : 1'b1;
      f3 = 3'($urandom_range(0, 7));
      if (wr && (f3 == 3'd4 || f3 == 3'd5)) f3 = f3 - 3'd4;
      a = ($urandom & ~32'(DEPTH * 4 - 1)) | 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) a = a & 32'h3F;
      junk = ($urandom_range(0, 3) == 0);
      do_xfer(rd, wr, f3, a, $urandom, junk);
    end

    // Final sweep: pool contents must match the model exactly.
    for (int i = 0; i < 16; i++) begin
      do_xfer(1, 0, 3'd2, 32'(i * 4), 32'h0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
